// File: rtl/nanov_store_tx.sv
// SPI write transmitter for nanoV store data: sends {CMD_WRITE, addr} then the
// store bytes little-endian by rotating the core's data_out buffer, then rotates it home.
module nanov_store_tx #(
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter int         ADDR_BITS = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [1:0]           i_size,
    input  logic [31:0]          i_data_in,
    output logic                 o_shift_data_out,
    output logic                 o_spi_cs_n,
    output logic                 o_spi_sck,
    output logic                 o_spi_mosi,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int HB = 8 + ADDR_BITS;
    localparam int CW = $clog2(2 * HB);
    localparam logic [CW-1:0] HDR_LAST  = CW'(2 * HB - 1);
    localparam logic [CW-1:0] PRE_ROT   = CW'(24);
    localparam logic [CW-1:0] BYTE_LAST = CW'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_ALIGN,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [HB-1:0]   r_hdr;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rot;
    logic [1:0]      r_byteIdx;
    logic [1:0]      r_lastIdx;
    logic            w_unusedData;

    assign w_unusedData = ^i_data_in[30:0];

    // r_rot tracks net rotation of the core buffer so RESTORE can bring it back to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_hdr     <= '0;
            r_cnt     <= '0;
            r_rot     <= '0;
            r_byteIdx <= '0;
            r_lastIdx <= '0;
        end else begin
            r_state <= w_next;
            if (o_shift_data_out) begin
                r_rot <= r_rot + 5'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_hdr     <= {CMD_WRITE, i_addr};
                        r_rot     <= '0;
                        r_cnt     <= '0;
                        r_byteIdx <= '0;
                        case (i_size)
                            2'b00:   r_lastIdx <= 2'd0;
                            2'b01:   r_lastIdx <= 2'd1;
                            default: r_lastIdx <= 2'd3;
                        endcase
                    end
                end
                S_HDR: begin
                    if (r_cnt[0]) begin
                        r_hdr <= {r_hdr[HB-2:0], 1'b0};
                    end
                    r_cnt <= (r_cnt == HDR_LAST) ? '0 : r_cnt + CW'(1);
                end
                S_DATA: begin
                    r_cnt <= (r_cnt == BYTE_LAST) ? '0 : r_cnt + CW'(1);
                end
                S_ALIGN: begin
                    r_cnt <= (r_cnt == BYTE_LAST) ? '0 : r_cnt + CW'(1);
                    if (r_cnt == BYTE_LAST) begin
                        r_byteIdx <= r_byteIdx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The final DATA phase1 shift lands rot on zero when r_rot==31, so RESTORE is skipped then.
    always_comb begin
        w_next           = r_state;
        o_shift_data_out = 1'b0;
        o_spi_cs_n       = 1'b1;
        o_spi_sck        = 1'b0;
        o_spi_mosi       = 1'b0;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                o_spi_cs_n       = 1'b0;
                o_spi_sck        = r_cnt[0];
                o_spi_mosi       = r_hdr[HB-1];
                o_shift_data_out = (r_cnt < PRE_ROT);
                if (r_cnt == HDR_LAST) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_spi_cs_n       = 1'b0;
                o_spi_sck        = r_cnt[0];
                o_spi_mosi       = i_data_in[31];
                o_shift_data_out = r_cnt[0];
                if (r_cnt == BYTE_LAST) begin
                    if (r_byteIdx != r_lastIdx) begin
                        w_next = S_ALIGN;
                    end else if (r_rot == 5'd31) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RESTORE;
                    end
                end
            end
            S_ALIGN: begin
                o_spi_cs_n       = 1'b0;
                o_shift_data_out = 1'b1;
                if (r_cnt == BYTE_LAST) begin
                    w_next = S_DATA;
                end
            end
            S_RESTORE: begin
                o_shift_data_out = 1'b1;
                if (r_rot == 5'd31) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nanov_store_tx.sv
// Bench for nanov_store_tx: models the core's rotating store buffer and scoreboards
// the MOSI byte stream, shift pulse counts, cs_n timing and latency.
module tb_nanov_store_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] addr;
    logic [1:0]  size;
    logic [31:0] coreBuf;
    logic        loadReq;
    logic [31:0] loadVal;
    logic        shiftOut;
    logic        csN;
    logic        sck;
    logic        mosi;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    nanov_store_tx dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_addr           (addr),
        .i_size           (size),
        .i_data_in        (coreBuf),
        .o_shift_data_out (shiftOut),
        .o_spi_cs_n       (csN),
        .o_spi_sck        (sck),
        .o_spi_mosi       (mosi),
        .o_busy           (busy),
        .o_done           (done)
    );

    typedef struct {
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] data;
        int          nBytes;
        int          csLow;
        int          pulses;
        int          restore;
        int          lat;
    } vec_t;

    vec_t        tbl[5];
    logic [7:0]  expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acceptCyc = 0;
    int          csLowCnt = 0;
    int          pulseCnt = 0;
    int          restoreCnt = 0;
    int          stabBad = 0;
    int          sckBad = 0;
    int          csLow0, pulse0, restore0, stab0, sck0;
    int          lat;
    logic [7:0]  rxByte = 8'h00;
    int          rxBits = 0;
    logic        prevMosi = 1'b0;

    // Core store buffer: rotates left whenever the block asks, or is reloaded by the bench.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (loadReq) begin
            coreBuf <= loadVal;
        end else if (shiftOut) begin
            coreBuf <= {coreBuf[30:0], coreBuf[31]};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: captures MOSI on every sck-high cycle and pops the scoreboard per byte.
    always @(negedge clk) begin
        if (!csN) csLowCnt++;
        if (shiftOut) pulseCnt++;
        if (csN && shiftOut) restoreCnt++;
        if (csN && sck) sckBad++;
        if (!csN && sck) begin
            if (mosi !== prevMosi) stabBad++;
            rxByte = {rxByte[6:0], mosi};
            rxBits++;
            if (rxBits == 8) begin
                rxBits = 0;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extraByte: got 0x%0h want none", rxByte);
                end else begin
                    checkOutput("mosiByte", 32'(rxByte), 32'(expQ.pop_front()));
                end
            end
        end
        if (csN) rxBits = 0;
        prevMosi = mosi;
    end

    task automatic loadCore(input logic [31:0] v);
        @(negedge clk);
        loadVal = v;
        loadReq = 1'b1;
        @(posedge clk);
        #1 loadReq = 1'b0;
    endtask

    task automatic pushExpected(input vec_t v);
        expQ.push_back(8'h02);
        expQ.push_back(v.addr[23:16]);
        expQ.push_back(v.addr[15:8]);
        expQ.push_back(v.addr[7:0]);
        for (int i = 0; i < v.nBytes; i++) begin
            expQ.push_back(v.data[8*i +: 8]);
        end
    endtask

    task automatic snap();
        csLow0   = csLowCnt;
        pulse0   = pulseCnt;
        restore0 = restoreCnt;
        stab0    = stabBad;
        sck0     = sckBad;
    endtask

    // Accepts one transfer, then scrambles addr/size to show they are latched.
    task automatic applyStimulus(input vec_t v);
        loadCore(v.data);
        pushExpected(v);
        @(negedge clk);
        addr  = v.addr;
        size  = v.size;
        start = 1'b1;
        snap();
        @(posedge clk);
        #1 acceptCyc = cyc;
        start = 1'b0;
        addr  = 24'($urandom);
        size  = 2'($urandom_range(0, 3));
    endtask

    task automatic waitDone(output int latOut);
        latOut = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                latOut = cyc - acceptCyc + 2;
                break;
            end
        end
    endtask

    task automatic checkTransfer(input vec_t v, input int latIn);
        checkOutput("latency", latIn, v.lat);
        checkOutput("csLowClocks", csLowCnt - csLow0, v.csLow);
        checkOutput("shiftPulses", pulseCnt - pulse0, v.pulses);
        checkOutput("restoreClocks", restoreCnt - restore0, v.restore);
        checkOutput("bufferRestored", coreBuf, v.data);
        checkOutput("bytesLeft", expQ.size(), 0);
        checkOutput("mosiStable", stabBad - stab0, 0);
        checkOutput("sckIdleLow", sckBad - sck0, 0);
        @(negedge clk);
        checkOutput("donePulse", 32'(done), 0);
        checkOutput("idleBusy", 32'(busy), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        addr    = '0;
        size    = '0;
        loadReq = 1'b0;
        loadVal = '0;

        tbl[0] = '{2'b10, 24'h000100, 32'h44332211, 4, 176, 128, 24, 202};
        tbl[1] = '{2'b00, 24'h123456, 32'hAABBCCDD, 1, 80, 32, 0, 82};
        tbl[2] = '{2'b01, 24'h00FFFE, 32'h0000BEEF, 2, 112, 64, 8, 122};
        tbl[3] = '{2'b11, 24'hFFFFFF, 32'hCAFEF00D, 4, 176, 128, 24, 202};
        tbl[4] = '{2'b01, 24'hABCDEF, 32'h80000001, 2, 112, 64, 8, 122};

        repeat (3) @(negedge clk);
        checkOutput("rstCsN", 32'(csN), 1);
        checkOutput("rstSck", 32'(sck), 0);
        checkOutput("rstMosi", 32'(mosi), 0);
        checkOutput("rstShift", 32'(shiftOut), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i]);
            waitDone(lat);
            checkTransfer(tbl[i], lat);
        end

        // start held high through a word transfer: second accept only after DONE
        loadCore(tbl[0].data);
        pushExpected(tbl[0]);
        @(negedge clk);
        addr  = tbl[0].addr;
        size  = tbl[0].size;
        start = 1'b1;
        snap();
        @(posedge clk);
        #1 acceptCyc = cyc;
        waitDone(lat);
        checkTransfer(tbl[0], lat);
        pushExpected(tbl[0]);
        snap();
        @(posedge clk);
        #1 acceptCyc = cyc;
        start = 1'b0;
        addr  = 24'h5A5A5A;
        size  = 2'b00;
        waitDone(lat);
        checkTransfer(tbl[0], lat);

        // start pulse in the middle of DATA is ignored
        applyStimulus(tbl[2]);
        repeat (80) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat);
        checkTransfer(tbl[2], lat);

        // reset during DATA byte 2 of a word transfer
        applyStimulus(tbl[0]);
        repeat (133) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstCsN", 32'(csN), 1);
        checkOutput("midRstSck", 32'(sck), 0);
        checkOutput("midRstShift", 32'(shiftOut), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        rst = 1'b0;
        while (expQ.size() > 0) void'(expQ.pop_front());
        applyStimulus(tbl[1]);
        waitDone(lat);
        checkTransfer(tbl[1], lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
